seq_divider: RTL



---
 rtl/arith_pkg.sv | 23 ++
 rtl/cla_sub4.sv | 46 ++++
 rtl/seq_divider.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the iterative arithmetic blocks.
//   state_t      : divider sequencing states (IDLE, RUN, DONE)
//   SLICE_W      : width of one borrow-lookahead subtractor slice
//   slice_count  : number of slices needed to cover a WIDTH+1 bit trial
//                  subtraction (WIDTH/4 + 1)
// ---------------------------------------------------------------------------
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

    function automatic int slice_count(input int width);
        return width / SLICE_W + 1;
    endfunction

endpackage

// File: rtl/cla_sub4.sv
// ---------------------------------------------------------------------------
// cla_sub4
// 4-bit borrow-lookahead subtractor slice: diff = a - b - borrow_in.
// Borrow generate g = ~a & b, borrow propagate p = ~(a ^ b); every internal
// borrow is expanded directly from borrow_in rather than rippled.
// Ports:
//   a, b        [3:0] in   minuend / subtrahend
//   borrow_in         in   borrow from the next-lower slice
//   diff        [3:0] out  difference
//   borrow_out        out  borrow into the next-higher slice
// ---------------------------------------------------------------------------
module cla_sub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       borrow_in,
    output logic [3:0] diff,
    output logic       borrow_out
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = ~a & b;
    assign w_p = ~(a ^ b);

    assign w_c[0] = borrow_in;
    assign w_c[1] = w_g[0]
                  | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1]
                  | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2]
                  | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3]
                  | (w_p[3] & w_g[2])
                  | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign diff       = a ^ b ^ w_c[3:0];
    assign borrow_out = w_c[4];

endmodule

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Iterative unsigned restoring divider, one quotient bit per clock.
// A division is accepted with start while not busy; WIDTH iterations later
// done pulses for one cycle with quotient/remainder/div_err valid. Results
// hold until overwritten by the next completed division.
//
// Optional feature macro: DIVIDER_ZERO_DETECT_EN
//   defined   : divisor 0 at accept skips RUN; DONE follows on the next edge
//               with quotient all ones, remainder = dividend, div_err = 1.
//   undefined : divisor 0 runs normally (same quotient/remainder arise
//               naturally); div_err is tied low.
//
// Ports:
//   clk                 in   rising-edge clock
//   rst                 in   synchronous active-high reset
//   start               in   request, sampled only when busy = 0
//   dividend  [WIDTH]   in   numerator, captured on the accepting edge
//   divisor   [WIDTH]   in   denominator, captured on the accepting edge
//   busy                out  division in progress
//   done                out  one-cycle completion pulse
//   quotient  [WIDTH]   out  result
//   remainder [WIDTH]   out  result
//   div_err             out  divide-by-zero flag, valid with done
//
// States:
//   IDLE | waiting for start
//   RUN  | one shift/trial-subtract per edge, counter counts down
//   DONE | done pulse; start here is accepted back-to-back
// ---------------------------------------------------------------------------
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_err
);

    localparam int NSLICE = slice_count(WIDTH);
    localparam int EXT_W  = NSLICE * SLICE_W;
    localparam int CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem_out;

    logic             w_div_zero;
    logic             w_last;
    logic [WIDTH:0]   w_shift;
    logic [EXT_W-1:0] w_sub_a;
    logic [EXT_W-1:0] w_sub_b;
    logic [EXT_W-1:0] w_diff;
    logic [NSLICE:0]  w_bchain;
    logic             w_keep;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quot_nxt;

`ifdef DIVIDER_ZERO_DETECT_EN
    logic             r_err;
    assign w_div_zero = (divisor == '0);
    assign div_err    = r_err;
`else
    assign w_div_zero = 1'b0;
    assign div_err    = 1'b0;
`endif

    assign w_last = (r_cnt == '0);

    // ---------------- trial subtraction ----------------
    // Shift the next dividend bit into the partial remainder, then subtract
    // the zero-extended divisor across the slice chain.
    assign w_shift = {r_rem, r_dvd[WIDTH-1]};
    assign w_sub_a = EXT_W'(w_shift);
    assign w_sub_b = EXT_W'(r_dvs);
    assign w_bchain[0] = 1'b0;

    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
        cla_sub4 u_sub (
            .a          (w_sub_a[gi*SLICE_W +: SLICE_W]),
            .b          (w_sub_b[gi*SLICE_W +: SLICE_W]),
            .borrow_in  (w_bchain[gi]),
            .diff       (w_diff[gi*SLICE_W +: SLICE_W]),
            .borrow_out (w_bchain[gi+1])
        );
    end

    // A non-negative difference is below the divisor, so its bits from WIDTH
    // upward are zero; any set bit there means the subtraction went negative,
    // exactly as the final borrow does.
    assign w_keep     = ~w_bchain[NSLICE] & ~(|w_diff[EXT_W-1:WIDTH]);
    assign w_rem_nxt  = w_keep ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quot_nxt = {r_dvd[WIDTH-2:0], w_keep};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = w_div_zero ? DONE : RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs (decoded from the state flop) ----------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    // The dividend register doubles as the quotient shift register: each
    // iteration consumes its MSB and shifts the new quotient bit in at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_quot    <= '0;
            r_rem_out <= '0;
`ifdef DIVIDER_ZERO_DETECT_EN
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_dvd <= dividend;
                        r_dvs <= divisor;
                        r_rem <= '0;
                        r_cnt <= CNT_LOAD;
`ifdef DIVIDER_ZERO_DETECT_EN
                        if (w_div_zero) begin
                            r_quot    <= '1;
                            r_rem_out <= dividend;
                            r_err     <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= w_quot_nxt;
                    if (w_last) begin
                        r_quot    <= w_quot_nxt;
                        r_rem_out <= w_rem_nxt;
`ifdef DIVIDER_ZERO_DETECT_EN
                        r_err     <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem_out;

endmodule
